// File: rtl/wbx_1master_pipe.sv
// wbx_1master_pipe
//   Wishbone B4 pipelined interconnect: one master fanned out to PERIPH_NUM slaves.
//   The slave index comes from the address bits above SLV_ADR_W. Up to MAX_PENDING
//   requests may be outstanding on one slave; the target never changes while any
//   are pending. Unmapped addresses are answered with ERR by the interconnect itself,
//   and a watchdog aborts transfers that a slave never answers.
//   Request and response paths are combinational, so the bus adds no latency.

module wbx_1master_pipe #(
  parameter int PERIPH_NUM  = 4,
  parameter int ADR_W       = 16,
  parameter int DAT_W       = 32,
  parameter int SLV_ADR_W   = 4,
  parameter int MAX_PENDING = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_ni,
  // slave side
  output logic [PERIPH_NUM-1:0]       wbs_cyc_i,
  output logic                        wbs_stb_i,
  output logic                        wbs_we_i,
  output logic [SLV_ADR_W-1:0]        wbs_adr_i,
  output logic [DAT_W/8-1:0]          wbs_sel_i,
  output logic [DAT_W-1:0]            wbs_dat_i,
  input  logic [PERIPH_NUM*DAT_W-1:0] wbs_dat_o,
  input  logic [PERIPH_NUM-1:0]       wbs_stall_o,
  input  logic [PERIPH_NUM-1:0]       wbs_ack_o,
  input  logic [PERIPH_NUM-1:0]       wbs_err_o,
  // master side
  input  logic                        wbm_cyc_o,
  input  logic                        wbm_stb_o,
  input  logic                        wbm_we_o,
  input  logic [ADR_W-1:0]            wbm_adr_o,
  input  logic [DAT_W/8-1:0]          wbm_sel_o,
  input  logic [DAT_W-1:0]            wbm_dat_o,
  output logic [DAT_W-1:0]            wbm_dat_i,
  output logic                        wbm_stall_i,
  output logic                        wbm_ack_i,
  output logic                        wbm_err_i
);

  localparam int IDX_W = ADR_W - SLV_ADR_W;
  // Selection code: 0..PERIPH_NUM-1 are slaves, PERIPH_NUM means "unmapped".
  localparam int SEL_W = $clog2(PERIPH_NUM + 1);
  localparam int PND_W = $clog2(MAX_PENDING + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [SEL_W-1:0] UNMAPPED   = SEL_W'(PERIPH_NUM);
  localparam logic [PND_W-1:0] PEND_MAX   = PND_W'(MAX_PENDING);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic             TIMEOUT_EN = 1'((TIMEOUT > 0) ? 1 : 0);

  // State
  logic [SEL_W-1:0] sel_q, sel_d;     // slave owning the outstanding transfers
  logic [PND_W-1:0] pend_q, pend_d;   // accepted but not yet answered
  logic [TMR_W-1:0] tmr_q, tmr_d;     // cycles waited without a response

  // Decode
  logic [IDX_W-1:0] idx_raw_s;
  logic             unmapped_s;
  logic [SEL_W-1:0] idx_s;

  // Slave fan-in
  logic             sel_ack_s;
  logic             sel_err_s;
  logic [DAT_W-1:0] sel_dat_s;
  logic             req_stall_s;

  // Control
  logic             req_s;
  logic             pending_s;
  logic             sel_unm_s;
  logic             resp_window_s;
  logic             resp_ack_s;
  logic             resp_err_s;
  logic             resp_s;
  logic             abort_s;
  logic             block_s;
  logic             stall_s;
  logic             accept_s;
  logic [SEL_W-1:0] tgt_s;

  // Address decode: out-of-range indices collapse onto the single UNMAPPED code.
  always_comb begin
    idx_raw_s  = wbm_adr_o[ADR_W-1:SLV_ADR_W];
    unmapped_s = (idx_raw_s >= IDX_W'(PERIPH_NUM));
    idx_s      = unmapped_s ? UNMAPPED : SEL_W'(idx_raw_s);
  end

  // Mux the owning slave's response lines and the requested slave's stall line.
  always_comb begin
    sel_ack_s   = 1'b0;
    sel_err_s   = 1'b0;
    sel_dat_s   = '0;
    req_stall_s = 1'b0;
    for (int k = 0; k < PERIPH_NUM; k++) begin
      sel_ack_s   = sel_ack_s | ((sel_q == SEL_W'(k)) & wbs_ack_o[k]);
      sel_err_s   = sel_err_s | ((sel_q == SEL_W'(k)) & wbs_err_o[k]);
      sel_dat_s   = sel_dat_s | ({DAT_W{sel_q == SEL_W'(k)}} & wbs_dat_o[k*DAT_W +: DAT_W]);
      req_stall_s = req_stall_s | ((idx_s == SEL_W'(k)) & wbs_stall_o[k]);
    end
  end

  // Response qualification, watchdog abort, flow control and target choice.
  always_comb begin
    req_s         = wbm_cyc_o & wbm_stb_o;
    pending_s     = (pend_q != '0);
    sel_unm_s     = (sel_q == UNMAPPED);
    // Responses only count while the cycle is open and something is outstanding.
    resp_window_s = wbm_cyc_o & pending_s;
    resp_ack_s    = resp_window_s & ~sel_unm_s & sel_ack_s;
    resp_err_s    = resp_window_s & (sel_unm_s | sel_err_s);
    resp_s        = resp_ack_s | resp_err_s;
    abort_s       = TIMEOUT_EN & resp_window_s & ~resp_s & (tmr_q == TMR_LAST);
    // A full pipe frees a slot in the cycle its oldest entry is answered; a
    // different target must wait until the pipe has fully drained. The slave
    // cannot see a request during an abort, so that cycle is blocked too.
    block_s       = req_s & (abort_s
                             | ((pend_q == PEND_MAX) & ~resp_s)
                             | (pending_s & (idx_s != sel_q)));
    stall_s       = block_s | (req_s & ~unmapped_s & req_stall_s);
    accept_s      = req_s & ~stall_s;
    // While blocked the bus stays with the slave that owns the pending work.
    tgt_s         = (req_s & ~block_s) ? idx_s : sel_q;
  end

  // Drive both bus sides; reset holds the slaves deselected and the master stalled.
  always_comb begin
    wbs_cyc_i = '0;
    for (int k = 0; k < PERIPH_NUM; k++) begin
      wbs_cyc_i[k] = wb_rst_ni & wbm_cyc_o & ~abort_s & (tgt_s == SEL_W'(k));
    end
    wbs_stb_i   = wbm_stb_o & ~block_s;
    wbs_we_i    = wbm_we_o;
    wbs_adr_i   = wbm_adr_o[SLV_ADR_W-1:0];
    wbs_sel_i   = wbm_sel_o;
    wbs_dat_i   = wbm_dat_o;
    wbm_stall_i = ~wb_rst_ni | stall_s;
    wbm_ack_i   = resp_ack_s;
    wbm_err_i   = resp_err_s | abort_s;
    // Interconnect-generated errors carry no data.
    wbm_dat_i   = (resp_ack_s | (resp_err_s & ~sel_unm_s)) ? sel_dat_s : '0;
  end

  // Next-state: owner tracking, pending count and watchdog timer.
  always_comb begin
    if (accept_s) begin
      sel_d = idx_s;
    end else begin
      sel_d = sel_q;
    end

    if (!wbm_cyc_o || abort_s) begin
      // Closing the cycle or aborting abandons everything outstanding.
      pend_d = '0;
      tmr_d  = '0;
    end else begin
      case ({accept_s, resp_s})
        2'b10:   pend_d = (pend_q == PEND_MAX) ? pend_q : pend_q + PND_W'(1);
        2'b01:   pend_d = pending_s ? pend_q - PND_W'(1) : pend_q;
        default: pend_d = pend_q;
      endcase
      if (TIMEOUT_EN && pending_s && !resp_s) begin
        tmr_d = tmr_q + TMR_W'(1);
      end else begin
        tmr_d = '0;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sel_q  <= '0;
      pend_q <= '0;
      tmr_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      pend_q <= pend_d;
      tmr_q  <= tmr_d;
    end
  end

endmodule
